// File: rtl/fu_cdb_arb_pkg.sv
//------------------------------------------------------------------------------
// fu_cdb_arb_pkg : types and helpers shared by the CDB writeback arbiter.
// Revision       : 1.0
//------------------------------------------------------------------------------
`ifndef PRF_IDX_W
`include "sys_defs.sv"
`endif
`default_nettype none

package fu_cdb_arb_pkg;

    localparam int XLEN      = 64;
    localparam int PRF_IDX_W = `PRF_IDX_W;
    localparam int ROB_W     = `ROB_IDX_W + 1;
    localparam int BR_MASK_W = `BR_MASK_W;

    typedef struct packed {
        logic                 valid;
        logic [XLEN-1:0]      result;
        logic [PRF_IDX_W-1:0] dest_tag;
        logic [ROB_W-1:0]     rob_idx;
        logic [BR_MASK_W-1:0] br_mask;
    } cdb_pkt_t;

    // A correctly resolved branch no longer guards the instruction.
    function automatic logic [BR_MASK_W-1:0] fix_br_mask(
        input logic [BR_MASK_W-1:0] mask,
        input logic                 correct,
        input logic [BR_MASK_W-1:0] tag
    );
        return correct ? (mask & ~tag) : mask;
    endfunction

endpackage

`default_nettype wire

// File: rtl/rr_arbiter.sv
//------------------------------------------------------------------------------
// rr_arbiter : combinational round-robin arbiter, one-hot grant from ptr_i up.
// Revision   : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module rr_arbiter #(
    parameter int N = 4
) (
    input  logic [N-1:0]         req_i,
    input  logic [$clog2(N)-1:0] ptr_i,
    output logic [N-1:0]         gnt_o
);

    localparam int PTR_W = $clog2(N);

    logic             w_found;
    logic [PTR_W-1:0] w_idx;

    always_comb begin
        gnt_o   = '0;
        w_found = 1'b0;
        w_idx   = '0;
        for (int k = 0; k < N; k++) begin
            w_idx = PTR_W'((int'(ptr_i) + k) % N);
            if (!w_found && req_i[w_idx]) begin
                gnt_o[w_idx] = 1'b1;
                w_found      = 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/sys_defs.sv
//------------------------------------------------------------------------------
// sys_defs : shared pipeline width macros used across execute/writeback RTL.
// Revision : 1.0
//------------------------------------------------------------------------------
`ifndef SYS_DEFS_SV
`define SYS_DEFS_SV
`default_nettype none

`define PRF_IDX_W 6
`define ROB_IDX_W 5
`define BR_MASK_W 4
// Number of common data buses; a multi-CDB writeback will key off this.
`define CDB_W     1

`default_nettype wire
`endif

// File: rtl/fu_cdb_arb.sv
//------------------------------------------------------------------------------
// fu_cdb_arb : round-robin sharing of one registered CDB among NUM_FU ALUs.
// Revision   : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module fu_cdb_arb
    import fu_cdb_arb_pkg::*;
#(
    parameter int NUM_FU = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_FU-1:0]           fu_done_i,
    input  logic [NUM_FU*XLEN-1:0]      fu_result_i,
    input  logic [NUM_FU*PRF_IDX_W-1:0] fu_dest_tag_i,
    input  logic [NUM_FU*ROB_W-1:0]     fu_rob_idx_i,
    input  logic [NUM_FU*BR_MASK_W-1:0] fu_br_mask_i,
    input  logic                        rob_br_recovery_i,
    input  logic                        rob_br_pred_correct_i,
    input  logic [BR_MASK_W-1:0]        rob_br_tag_fix_i,
    output logic [NUM_FU-1:0]           fu_stall_o,
    output logic                        cdb_valid_o,
    output logic [XLEN-1:0]             cdb_result_o,
    output logic [PRF_IDX_W-1:0]        cdb_dest_tag_o,
    output logic [ROB_W-1:0]            cdb_rob_idx_o,
    output logic [BR_MASK_W-1:0]        cdb_br_mask_o
);

    localparam int PTR_W = $clog2(NUM_FU);

    logic [PTR_W-1:0]     ptr_q, ptr_d;
    cdb_pkt_t             cdb_q, cdb_d;
    logic [NUM_FU-1:0]    w_elig, w_gnt;
    logic [PTR_W-1:0]     w_gnt_idx;
    logic [BR_MASK_W-1:0] w_mask;

    // Recovery blocks grants and stalls; the ALUs squash or freeze themselves.
    assign w_elig = fu_done_i & ~{NUM_FU{rob_br_recovery_i}};

    rr_arbiter #(.N(NUM_FU)) u_rr (
        .req_i (w_elig),
        .ptr_i (ptr_q),
        .gnt_o (w_gnt)
    );

    assign fu_stall_o = rst ? '0 : (fu_done_i & ~w_gnt & ~{NUM_FU{rob_br_recovery_i}});

    always_comb begin
        cdb_d     = '0;
        w_gnt_idx = '0;
        w_mask    = '0;
        for (int i = 0; i < NUM_FU; i++) begin
            if (w_gnt[i]) begin
                w_gnt_idx      = PTR_W'(i);
                cdb_d.result   = fu_result_i[XLEN*i +: XLEN];
                cdb_d.dest_tag = fu_dest_tag_i[PRF_IDX_W*i +: PRF_IDX_W];
                cdb_d.rob_idx  = fu_rob_idx_i[ROB_W*i +: ROB_W];
                w_mask         = fu_br_mask_i[BR_MASK_W*i +: BR_MASK_W];
            end
        end
        cdb_d.valid   = |w_gnt;
        cdb_d.br_mask = fix_br_mask(w_mask, rob_br_pred_correct_i, rob_br_tag_fix_i);

        ptr_d = ptr_q;
        if (|w_gnt) begin
            ptr_d = (w_gnt_idx == PTR_W'(NUM_FU - 1)) ? '0 : w_gnt_idx + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cdb_q <= '0;
            ptr_q <= '0;
        end else begin
            cdb_q <= cdb_d;
            ptr_q <= ptr_d;
        end
    end

    assign cdb_valid_o    = cdb_q.valid;
    assign cdb_result_o   = cdb_q.result;
    assign cdb_dest_tag_o = cdb_q.dest_tag;
    assign cdb_rob_idx_o  = cdb_q.rob_idx;
    assign cdb_br_mask_o  = cdb_q.br_mask;

endmodule

`default_nettype wire

// File: tb/tb_fu_cdb_arb.sv
//------------------------------------------------------------------------------
// tb_fu_cdb_arb : directed self-checking bench for the CDB writeback arbiter.
// Revision      : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_fu_cdb_arb;
    import fu_cdb_arb_pkg::*;

    localparam int N = 4;

    logic                   clk;
    logic                   rst;
    logic [N-1:0]           done;
    logic [N*XLEN-1:0]      res;
    logic [N*PRF_IDX_W-1:0] tag;
    logic [N*ROB_W-1:0]     rob;
    logic [N*BR_MASK_W-1:0] mask;
    logic                   rec;
    logic                   pc;
    logic [BR_MASK_W-1:0]   tfix;
    logic [N-1:0]           stall;
    logic                   cvalid;
    logic [XLEN-1:0]        cres;
    logic [PRF_IDX_W-1:0]   ctag;
    logic [ROB_W-1:0]       crob;
    logic [BR_MASK_W-1:0]   cmask;

    int errors = 0;
    int checks = 0;

    fu_cdb_arb #(.NUM_FU(N)) dut (
        .clk                   (clk),
        .rst                   (rst),
        .fu_done_i             (done),
        .fu_result_i           (res),
        .fu_dest_tag_i         (tag),
        .fu_rob_idx_i          (rob),
        .fu_br_mask_i          (mask),
        .rob_br_recovery_i     (rec),
        .rob_br_pred_correct_i (pc),
        .rob_br_tag_fix_i      (tfix),
        .fu_stall_o            (stall),
        .cdb_valid_o           (cvalid),
        .cdb_result_o          (cres),
        .cdb_dest_tag_o        (ctag),
        .cdb_rob_idx_o         (crob),
        .cdb_br_mask_o         (cmask)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ALU i defaults: result 0x100+i, tag 10+i, rob i+1, mask 0.
    task automatic load_defaults();
        for (int i = 0; i < N; i++) begin
            res[XLEN*i +: XLEN]            = 64'h100 + 64'(i);
            tag[PRF_IDX_W*i +: PRF_IDX_W]  = PRF_IDX_W'(10 + i);
            rob[ROB_W*i +: ROB_W]          = ROB_W'(i + 1);
            mask[BR_MASK_W*i +: BR_MASK_W] = '0;
        end
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b1; done = '0; rec = 1'b0; pc = 1'b0; tfix = '0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1; done = 4'hF;
        #1;
        checks++; if (stall !== 4'h0) begin errors++; $display("FAIL reset_stall: got %h want 0", stall); end
        @(negedge clk);
        @(negedge clk);
        checks++; if (cvalid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", cvalid); end
        checks++; if (cres !== 64'h0) begin errors++; $display("FAIL reset_result: got %h want 0", cres); end
        checks++; if (dut.ptr_q !== 2'd0) begin errors++; $display("FAIL reset_ptr: got %0d want 0", dut.ptr_q); end
        rst = 1'b0; done = '0;
    endtask

    task automatic test_single();
        @(negedge clk);
        res[63:0] = 64'h5; done = 4'b0001;
        #1;
        checks++; if (stall !== 4'h0) begin errors++; $display("FAIL single_stall: got %h want 0", stall); end
        @(negedge clk);
        checks++; if (cvalid !== 1'b1) begin errors++; $display("FAIL single_valid: got %b want 1", cvalid); end
        checks++; if (cres !== 64'h5) begin errors++; $display("FAIL single_result: got %h want 5", cres); end
        checks++; if (ctag !== 6'd10) begin errors++; $display("FAIL single_tag: got %0d want 10", ctag); end
        checks++; if (crob !== 6'd1) begin errors++; $display("FAIL single_rob: got %0d want 1", crob); end
        checks++; if (dut.ptr_q !== 2'd1) begin errors++; $display("FAIL single_ptr: got %0d want 1", dut.ptr_q); end
        done = '0;
        @(negedge clk);
        checks++; if (cvalid !== 1'b0 || cres !== 64'h0) begin errors++; $display("FAIL single_idle: got valid=%b res=%h want 0/0", cvalid, cres); end
        res[63:0] = 64'h100;
    endtask

    task automatic test_round_robin();
        logic [N-1:0] done_tbl [4] = '{4'hF, 4'hE, 4'hC, 4'h8};
        logic [N-1:0] stl_tbl  [4] = '{4'hE, 4'hC, 4'h8, 4'h0};
        logic [1:0]   ptr_tbl  [4] = '{2'd1, 2'd2, 2'd3, 2'd0};
        int bc = 0;
        apply_reset();
        for (int k = 0; k < 4; k++) begin
            done = done_tbl[k];
            #1;
            checks++; if (stall !== stl_tbl[k]) begin errors++; $display("FAIL rr_stall[%0d]: got %h want %h", k, stall, stl_tbl[k]); end
            @(negedge clk);
            if (cvalid === 1'b1) bc++;
            checks++; if (cres !== 64'h100 + 64'(k)) begin errors++; $display("FAIL rr_result[%0d]: got %h want %h", k, cres, 64'h100 + 64'(k)); end
            checks++; if (dut.ptr_q !== ptr_tbl[k]) begin errors++; $display("FAIL rr_ptr[%0d]: got %0d want %0d", k, dut.ptr_q, ptr_tbl[k]); end
        end
        done = '0;
        @(negedge clk);
        if (cvalid === 1'b1) bc++;
        checks++; if (bc !== 4) begin errors++; $display("FAIL rr_broadcasts: got %0d want 4", bc); end
    endtask

    task automatic test_wrap();
        done = 4'b0010;
        @(negedge clk);
        checks++; if (dut.ptr_q !== 2'd2) begin errors++; $display("FAIL wrap_setup_ptr: got %0d want 2", dut.ptr_q); end
        done = 4'b0011;
        #1;
        checks++; if (stall !== 4'b0010) begin errors++; $display("FAIL wrap_stall0: got %h want 2", stall); end
        @(negedge clk);
        checks++; if (cres !== 64'h100) begin errors++; $display("FAIL wrap_first: got %h want 100", cres); end
        checks++; if (dut.ptr_q !== 2'd1) begin errors++; $display("FAIL wrap_ptr1: got %0d want 1", dut.ptr_q); end
        done = 4'b0010;
        #1;
        checks++; if (stall !== 4'b0000) begin errors++; $display("FAIL wrap_stall1: got %h want 0", stall); end
        @(negedge clk);
        checks++; if (cres !== 64'h101) begin errors++; $display("FAIL wrap_second: got %h want 101", cres); end
        checks++; if (dut.ptr_q !== 2'd2) begin errors++; $display("FAIL wrap_ptr2: got %0d want 2", dut.ptr_q); end
        done = '0;
    endtask

    task automatic test_recovery();
        @(negedge clk);
        done = 4'b0010;
        @(negedge clk);
        done = 4'b0110; rec = 1'b1;
        #1;
        checks++; if (cvalid !== 1'b1 || cres !== 64'h101) begin errors++; $display("FAIL rec_inflight: got valid=%b res=%h want 1/101", cvalid, cres); end
        checks++; if (stall !== 4'b0000) begin errors++; $display("FAIL rec_stall: got %h want 0", stall); end
        @(negedge clk);
        checks++; if (cvalid !== 1'b0 || cres !== 64'h0) begin errors++; $display("FAIL rec_valid: got valid=%b res=%h want 0/0", cvalid, cres); end
        checks++; if (dut.ptr_q !== 2'd2) begin errors++; $display("FAIL rec_ptr: got %0d want 2", dut.ptr_q); end
        rec = 1'b0; done = '0;
    endtask

    task automatic test_mask_fix();
        @(negedge clk);
        mask[3:0] = 4'b0101; done = 4'b0001; pc = 1'b1; tfix = 4'b0001;
        @(negedge clk);
        checks++; if (cvalid !== 1'b1 || cmask !== 4'b0100) begin errors++; $display("FAIL mask_clear: got valid=%b mask=%b want 1/0100", cvalid, cmask); end
        pc = 1'b0;
        @(negedge clk);
        checks++; if (cmask !== 4'b0101) begin errors++; $display("FAIL mask_nocorrect: got %b want 0101", cmask); end
        pc = 1'b1; tfix = 4'b0010;
        @(negedge clk);
        checks++; if (cmask !== 4'b0101) begin errors++; $display("FAIL mask_othertag: got %b want 0101", cmask); end
        done = '0; pc = 1'b0; tfix = '0; mask[3:0] = 4'b0000;
    endtask

    task automatic test_rst_midop();
        @(negedge clk);
        done = 4'hF; mask[3:0] = 4'b0011;
        @(negedge clk);
        checks++; if (cvalid !== 1'b1) begin errors++; $display("FAIL midrst_pre: got %b want 1", cvalid); end
        rst = 1'b1;
        #1;
        checks++; if (stall !== 4'h0) begin errors++; $display("FAIL midrst_stall: got %h want 0", stall); end
        @(negedge clk);
        checks++; if (cvalid !== 1'b0 || cres !== 64'h0 || ctag !== '0 || crob !== '0 || cmask !== '0) begin
            errors++; $display("FAIL midrst_outputs: got v=%b r=%h t=%h rob=%h m=%h want all 0", cvalid, cres, ctag, crob, cmask);
        end
        checks++; if (dut.ptr_q !== 2'd0) begin errors++; $display("FAIL midrst_ptr: got %0d want 0", dut.ptr_q); end
        rst = 1'b0; done = '0; mask[3:0] = 4'b0000;
    endtask

    initial begin
        rst = 1'b1; done = '0; rec = 1'b0; pc = 1'b0; tfix = '0;
        load_defaults();
        test_reset();
        test_single();
        test_round_robin();
        test_wrap();
        test_recovery();
        test_mask_fix();
        test_rst_midop();
        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
